// File: rtl/armleocpu_storegen_if.sv
// Store-path bundle: execute-stage request, memory write port, hazard probe
// and drain status.
interface armleocpu_storegen_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [2:0]  s_type;
  logic [31:0] s_data;
  logic        s_missaligned;
  logic        s_unknowntype;

  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  logic [31:0] chk_addr;
  logic        chk_hit;
  logic        empty;

  // slave = the store generator; master = execute stage plus memory side
  modport slave (
    input  s_valid, s_addr, s_type, s_data, m_ready, chk_addr,
    output s_ready, s_missaligned, s_unknowntype,
           m_valid, m_addr, m_wdata, m_wstrb, chk_hit, empty
  );

  modport master (
    output s_valid, s_addr, s_type, s_data, m_ready, chk_addr,
    input  s_ready, s_missaligned, s_unknowntype,
           m_valid, m_addr, m_wdata, m_wstrb, chk_hit, empty
  );
endinterface

// File: rtl/armleocpu_storegen.sv
// Store data/strobe generator with a small in-order store buffer draining
// to the data-memory write port, plus a word-address hazard check.
module armleocpu_storegen #(
  parameter int DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  armleocpu_storegen_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [2:0] STORE_BYTE = 3'b000;
  localparam logic [2:0] STORE_HALF = 3'b001;
  localparam logic [2:0] STORE_WORD = 3'b010;

  logic [29:0] addr_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic [3:0]  wstrb_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]  off;
  logic [31:0] gen_wdata;
  logic [3:0]  gen_wstrb;
  logic        gen_mis, gen_unk;
  logic        err, full, enq, deq;

  assign off = bus.s_addr[1:0];

  always_comb begin
    gen_wdata = bus.s_data;
    gen_wstrb = 4'b0000;
    gen_mis   = 1'b0;
    gen_unk   = 1'b0;
    case (bus.s_type)
      STORE_BYTE: begin
        gen_wdata = {4{bus.s_data[7:0]}};
        gen_wstrb = 4'b0001 << off;
      end
      STORE_HALF: begin
        gen_wdata = {2{bus.s_data[15:0]}};
        gen_wstrb = 4'b0011 << off;
        gen_mis   = off[0];
      end
      STORE_WORD: begin
        gen_wstrb = 4'b1111;
        gen_mis   = |off;
      end
      default: gen_unk = 1'b1;
    endcase
  end

  // Handshake: a transfer happens on any edge where valid & ready are both
  // high; valid never waits on ready, and an erroneous request is consumed
  // (ready=1) without being buffered so the trap can be taken upstream.
  assign bus.s_missaligned = bus.s_valid & gen_mis;
  assign bus.s_unknowntype = bus.s_valid & gen_unk;
  assign err  = bus.s_missaligned | bus.s_unknowntype;
  assign full = (count == CW'(DEPTH));
  assign bus.empty   = (count == '0);
  assign bus.s_ready = err | ~full;
  assign bus.m_valid = ~bus.empty;

  assign enq = bus.s_valid & bus.s_ready & ~err;
  assign deq = bus.m_valid & bus.m_ready;

  assign bus.m_addr  = {addr_mem[rd_ptr], 2'b00};
  assign bus.m_wdata = wdata_mem[rd_ptr];
  assign bus.m_wstrb = wstrb_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr]  <= bus.s_addr[31:2];
      wdata_mem[wr_ptr] <= gen_wdata;
      wstrb_mem[wr_ptr] <= gen_wstrb;
    end
  end

  logic [PW-1:0] rel [DEPTH];
  logic          hit;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rel[i] = PW'(i) - rd_ptr;
      if (({1'b0, rel[i]} < count) && (addr_mem[i] == bus.chk_addr[31:2]))
        hit = 1'b1;
    end
  end

  assign bus.chk_hit = hit;
endmodule

// File: tb/tb_armleocpu_storegen.sv
// Directed plus randomized bench for armleocpu_storegen against a queue-based
// reference model of the store buffer.
module tb_armleocpu_storegen;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  armleocpu_storegen_if bus();

  armleocpu_storegen #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  // entry = {word addr[31:0], wdata[31:0], wstrb[3:0]}
  logic [67:0] exp_q[$];

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_gen(input logic [31:0] addr, input logic [2:0] typ,
                                    input logic [31:0] data, output logic mis,
                                    output logic unk, output logic [31:0] wd,
                                    output logic [3:0] ws);
    int unsigned o;
    o   = addr % 4;
    mis = 1'b0;
    unk = 1'b0;
    wd  = 32'h0;
    ws  = 4'h0;
    case (typ)
      3'd0: begin
        wd = 32'(data[7:0]) * 32'h01010101;
        ws = 4'(1 << o);
      end
      3'd1: begin
        wd  = 32'(data[15:0]) * 32'h00010001;
        ws  = 4'(3 << o);
        mis = (o % 2) != 0;
      end
      3'd2: begin
        wd  = data;
        ws  = 4'hF;
        mis = (o != 0);
      end
      default: unk = 1'b1;
    endcase
  endfunction

  // Check every output against the model, advance the model, then step one edge.
  task automatic cycle();
    logic mis, unk, err, exp_ready, exp_hit;
    logic [31:0] wd;
    logic [3:0]  ws;
    model_gen(bus.s_addr, bus.s_type, bus.s_data, mis, unk, wd, ws);
    if (!bus.s_valid) begin
      mis = 1'b0;
      unk = 1'b0;
    end
    err       = mis | unk;
    exp_ready = err || (exp_q.size() < DEPTH);
    exp_hit   = 1'b0;
    foreach (exp_q[i])
      if (exp_q[i][67:38] == bus.chk_addr[31:2]) exp_hit = 1'b1;
    #4;
    chk("s_ready", 68'(bus.s_ready), 68'(exp_ready));
    chk("s_missaligned", 68'(bus.s_missaligned), 68'(mis));
    chk("s_unknowntype", 68'(bus.s_unknowntype), 68'(unk));
    chk("m_valid", 68'(bus.m_valid), 68'(exp_q.size() != 0));
    chk("empty", 68'(bus.empty), 68'(exp_q.size() == 0));
    chk("chk_hit", 68'(bus.chk_hit), 68'(exp_hit));
    if (exp_q.size() != 0) begin
      chk("head_beat", {bus.m_addr, bus.m_wdata, bus.m_wstrb}, exp_q[0]);
      if (bus.m_ready) void'(exp_q.pop_front());
    end
    if (bus.s_valid && exp_ready && !err)
      exp_q.push_back({bus.s_addr & 32'hFFFF_FFFC, wd, ws});
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] data);
    bus.s_valid = 1'b1;
    bus.s_addr  = addr;
    bus.s_type  = typ;
    bus.s_data  = data;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.s_valid  = 1'b0;
    bus.s_addr   = 32'h0;
    bus.s_type   = 3'd0;
    bus.s_data   = 32'h0;
    bus.m_ready  = 1'b0;
    bus.chk_addr = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // byte store, drained one cycle after acceptance
    bus.m_ready = 1'b1;
    put(32'h1003, 3'd0, 32'h0000_00A5);
    cycle();
    idle(2);

    // half store aligned, then misaligned
    put(32'h2002, 3'd1, 32'h1234_BEEF);
    cycle();
    idle(2);
    put(32'h2001, 3'd1, 32'h1234_BEEF);
    cycle();
    idle(2);

    // misaligned word and unknown type
    put(32'h3002, 3'd2, 32'hCAFE_F00D);
    cycle();
    put(32'h3000, 3'd3, 32'hCAFE_F00D);
    cycle();
    put(32'h3000, 3'd7, 32'hCAFE_F00D);
    cycle();
    idle(2);

    // backpressure: third store waits until the first drains
    bus.m_ready = 1'b0;
    put(32'h5000, 3'd2, 32'h1111_1111);
    cycle();
    put(32'h5004, 3'd2, 32'h2222_2222);
    cycle();
    put(32'h5008, 3'd2, 32'h3333_3333);
    for (int i = 0; i < 3; i++) cycle();
    bus.m_ready = 1'b1;
    cycle();
    cycle();
    idle(4);

    // hazard check
    bus.m_ready = 1'b0;
    put(32'h4004, 3'd2, 32'hDEAD_BEEF);
    bus.chk_addr = 32'h4004;
    cycle();
    bus.s_valid  = 1'b0;
    bus.chk_addr = 32'h4007;
    cycle();
    bus.chk_addr = 32'h4008;
    cycle();
    bus.chk_addr = 32'h4004;
    bus.m_ready  = 1'b1;
    cycle();
    idle(2);

    // reset with two entries pending
    bus.m_ready = 1'b0;
    put(32'h6000, 3'd2, 32'h6666_6666);
    cycle();
    put(32'h6004, 3'd0, 32'h0000_0077);
    cycle();
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    bus.m_ready = 1'b1;
    idle(3);

    // randomized traffic over a small address window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      bus.s_valid  = ($urandom_range(0, 3) != 0);
      bus.s_addr   = 32'h4000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      bus.s_type   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                 : 3'($urandom_range(0, 2));
      bus.s_data   = $urandom;
      bus.m_ready  = ($urandom_range(0, 2) != 0);
      bus.chk_addr = 32'h4000 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
      cycle();
    end
    bus.m_ready = 1'b1;
    idle(DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
